// File: rtl/audio_src_switch.sv
// audio_src_switch: click-free selector of one of NUM_CH 1-bit audio streams.
// A channel change waits for the old source to go low (bounded by WAIT_MAX),
// inserts MUTE_CYCLES of silence, then routes the new source. Global mute
// gates the output without touching the switching sequence.
module audio_src_switch #(
    parameter int NUM_CH      = 4,
    parameter int SEL_W       = 2,
    parameter int MUTE_CYCLES = 1024,
    parameter int WAIT_MAX    = 65536,
    parameter int CNT_W       = 17
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NUM_CH-1:0] audio_in,
    input  logic [SEL_W-1:0]  sel,
    input  logic              mute,
    output logic              audio,
    output logic [SEL_W-1:0]  active_ch,
    output logic              busy,
    output logic              switch_done
);

    typedef enum logic [1:0] {
        PASS     = 2'd0,
        WAIT_LOW = 2'd1,
        GAP      = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_RELOAD = CNT_W'(WAIT_MAX - 1);
    localparam logic [CNT_W-1:0] MUTE_RELOAD = CNT_W'(MUTE_CYCLES - 1);

    state_t           state, stateNext;
    logic [CNT_W-1:0] counter, counterNext;
    logic [SEL_W-1:0] target, targetNext, activeNext;
    logic             doneNext;
    logic             selValid;
    logic             curSrc;

    // Requests outside the populated channel range are ignored everywhere.
    assign selValid = int'(sel) < NUM_CH;

    // Mux of the currently routed source; a loop avoids index-width issues
    // when NUM_CH is not a power of two.
    always_comb begin
        curSrc = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(active_ch) == i) curSrc = audio_in[i];
        end
    end

    // Next-state logic: PASS -> WAIT_LOW -> GAP -> PASS, abort only in WAIT_LOW.
    always_comb begin
        stateNext   = state;
        counterNext = counter;
        targetNext  = target;
        activeNext  = active_ch;
        doneNext    = 1'b0;
        case (state)
            PASS: begin
                if (selValid && sel != active_ch) begin
                    targetNext  = sel;
                    counterNext = WAIT_RELOAD;
                    stateNext   = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (selValid && sel == active_ch) begin
                    stateNext = PASS;
                end else begin
                    if (selValid) targetNext = sel;
                    // Old source low or timeout: either way a single move to GAP.
                    if (!curSrc || counter == '0) begin
                        counterNext = MUTE_RELOAD;
                        stateNext   = GAP;
                    end else begin
                        counterNext = counter - 1'b1;
                    end
                end
            end
            GAP: begin
                if (selValid) targetNext = sel;
                if (counter == '0) begin
                    // A request arriving on the last gap cycle still counts.
                    activeNext = targetNext;
                    doneNext   = 1'b1;
                    stateNext  = PASS;
                end else begin
                    counterNext = counter - 1'b1;
                end
            end
            default: stateNext = PASS;
        endcase
    end

    // State and registered outputs; audio is silenced while in GAP.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= PASS;
            counter     <= '0;
            target      <= '0;
            active_ch   <= '0;
            busy        <= 1'b0;
            switch_done <= 1'b0;
            audio       <= 1'b0;
        end else begin
            state       <= stateNext;
            counter     <= counterNext;
            target      <= targetNext;
            active_ch   <= activeNext;
            busy        <= (stateNext != PASS);
            switch_done <= doneNext;
            audio       <= (state == GAP) ? 1'b0 : (curSrc & ~mute);
        end
    end

endmodule

// File: doc/audio_src_switch.md
Name: audio_src_switch

Overview:
- Parametrised, click-free audio source selector for the tone generator output path.
- Takes NUM_CH 1-bit audio streams (note generator, song player, future voices) and forwards one of them to the speaker/PWM pin, registered on CLK.
- A source change never cuts a high pulse short. The switch waits for the old source to go low (bounded by a timeout), inserts a programmable silent gap, then swaps to the new source.
- Also provides a global mute.

Parameters:
- NUM_CH, 4, number of audio source channels (2..16).
- SEL_W, 2, width of sel and active_ch; must satisfy 2^SEL_W >= NUM_CH.
- MUTE_CYCLES, 1024, length of the silent gap inserted between sources, in CLK cycles (>= 1).
- WAIT_MAX, 65536, maximum cycles to wait for the old source to go low before forcing the switch (>= 1).
- CNT_W, 17, width of the internal down-counter; must hold max(MUTE_CYCLES, WAIT_MAX).

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- audio_in  input  NUM_CH  audio streams; bit i is channel i.
- sel  input  SEL_W  requested channel; values >= NUM_CH are ignored.
- mute  input  1  forces audio to 0 while high; does not affect the switching FSM.
- audio  output  1  registered selected audio.
- active_ch  output  SEL_W  channel currently routed to audio.
- busy  output  1  high while a switch is in progress (WAIT_LOW or GAP).
- switch_done  output  1  one-cycle pulse in the cycle active_ch takes its new value.

Behaviour:
- Reset (RST_N low, asynchronous): audio=0, active_ch=0, busy=0, switch_done=0, state=PASS, counter=0, target=0. On release, operation starts in PASS routing channel 0.
- Registered output, 1-cycle latency: in PASS and WAIT_LOW, audio <= audio_in[active_ch] & ~mute. In GAP, audio <= 0.
- busy is registered: high exactly in the cycles state is WAIT_LOW or GAP.
- sel valid means sel < NUM_CH. Invalid sel is ignored in every state: no target update, no state change.
- PASS:
  - valid sel != active_ch: target <= sel, counter <= WAIT_MAX-1, go to WAIT_LOW.
  - Otherwise stay in PASS.
- WAIT_LOW (old source still routed):
  - Valid sel == active_ch: abort to PASS. No gap, no switch_done.
  - Else if valid sel: target <= sel, updated every cycle.
  - If audio_in[active_ch]==0, or counter==0 (timeout): counter <= MUTE_CYCLES-1, go to GAP.
  - Else counter decrements.
- GAP:
  - audio held 0. Valid sel continues to update target (no abort in GAP).
  - Counter decrements. When counter==0: active_ch <= target, switch_done <= 1 for one cycle, go to PASS.
  - If target equals the old active_ch at this point, the gap still completes and switch_done still pulses.
  - Gap length is exactly MUTE_CYCLES cycles of audio=0 in the GAP state.
- Re-trigger: a sel differing from the new active_ch in the first PASS cycle after GAP starts a fresh WAIT_LOW.
- mute is orthogonal: asserting it mid-switch forces audio=0 but does not stall the counter or the FSM.
- Simultaneous old-source low and timeout in WAIT_LOW: single transition to GAP.
- Reset asserted mid-switch: everything returns to reset values immediately; the pending target is discarded.
- Counter arithmetic is unsigned CNT_W. It never wraps, because it is reloaded before reaching 0 is acted upon.

Test Plan:
- Reset/pass (NUM_CH=4, MUTE_CYCLES=4, WAIT_MAX=8): RST_N low then high, sel=0, audio_in[0] toggling -> audio follows audio_in[0] one cycle late; active_ch=0; busy=0.
- Clean switch: audio_in[0]=1 held, sel=2 at t0, audio_in[0] drops at t0+3 -> busy=1 from t0+1; audio=1 until the drop; then exactly 4 cycles audio=0; switch_done pulses once; active_ch=2; audio follows audio_in[2].
- Timeout: audio_in[0] stuck 1, sel=1 -> after 8 WAIT_LOW cycles, 4-cycle gap, then active_ch=1 with switch_done pulse.
- Abort and retarget: sel 0->3 then back to 0 during WAIT_LOW -> PASS, no gap, no switch_done. sel 0->1, then sel=3 during GAP -> active_ch ends at 3 after one gap.
- Invalid/mute: NUM_CH=3, sel=3 -> no state change, busy stays 0. mute=1 during GAP and PASS -> audio=0; FSM timing unchanged.
- Async reset mid-GAP: RST_N pulsed low between clock edges -> audio=0, active_ch=0, busy=0 immediately, without waiting for an edge.
